comm_arbiter: RTL and testbench
===============================

COMM_ARBITER -- requirements
Module: comm_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1_000_000, response-wait limit in clk cycles; legal range 2..2^20-1.
REQ-002 Port: clk  input  1  clock; all flops rising-edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: req0/req1  input  1  one-cycle command request pulse from requester 0/1.
REQ-005 Ports: cmd0/cmd1  input  8  command byte, sampled with req0/req1.
REQ-006 Ports: data0/data1  input  16  data word, sampled with req0/req1.
REQ-007 Ports: busy0/busy1  output  1  requester has a pending or in-flight command.
REQ-008 Ports: done0/done1  output  1  one-cycle pulse when that requester's transaction finishes.
REQ-009 Ports: err0/err1  output  1  one-cycle pulse coincident with done on timeout.
REQ-010 Ports: resp0/resp1  output  8  response byte, valid while done pulses, held until next done.
REQ-011 Ports: snd_cmd  output  1, cmd  output  8, data  output  16: command-master frame request.
REQ-012 Ports: resp  input  8, resp_rdy  input  1: response byte and its one-cycle valid from the command master.

Function
REQ-013 Slot capture: req_i with busy_i low SHALL set pending_i and latch cmd_i/data_i next edge; req_i with busy_i high SHALL be ignored (no overwrite).
REQ-014 busy_i SHALL equal pending_i OR (owner==i AND state!=IDLE).
REQ-015 FSM states: IDLE, SEND, WAIT; reset state IDLE.
REQ-016 IDLE: if any pending, grant, set owner, clear owner's pending, go SEND; else stay.
REQ-017 Arbitration: single pending wins; both pending -> requester != last_grant wins; last_grant updates on grant.
REQ-018 SEND: snd_cmd=1 exactly this one cycle; cmd/data = owner's latched values; go WAIT; wait counter cleared.
REQ-019 cmd/data outputs SHALL be stable from SEND through return to IDLE; 0 in IDLE until first grant, then hold last values.
REQ-020 WAIT: counter increments each cycle; resp_rdy -> resp_owner<=resp, done_owner pulses next cycle, go IDLE.
REQ-021 WAIT timeout: counter==TIMEOUT-1 without resp_rdy -> resp_owner<=8'h00, done_owner and err_owner pulse next cycle, go IDLE.
REQ-022 resp_rdy in same cycle as timeout condition SHALL win (normal completion, no err).
REQ-023 resp_rdy in IDLE or SEND SHALL be ignored.
REQ-024 Latency: req pulse cycle N, arbiter idle, no competitor -> snd_cmd high in cycle N+2.
REQ-025 Back-to-back: next grant decided in the IDLE cycle concurrent with the done pulse; no bubble beyond that cycle.
REQ-026 done/err/resp outputs SHALL be registered; non-owner done/err stay 0.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, pending 0, owner 0, last_grant 1, counter 0, snd_cmd/done/err 0, cmd/data/resp0/resp1 0.
REQ-028 Reset mid-transaction SHALL drop the transaction with no done/err; the command master frame is not aborted by this block.

Structure
REQ-029 Shared package comm_pkg SHALL hold arbiter state enum typedef and NUM_REQ=2 constant.
REQ-030 Per-requester capture (pending flag + cmd/data regs + busy) SHALL be sub-module cmd_slot, instantiated twice.
REQ-031 Timeout counter width SHALL be 20 bits.

Verification (TIMEOUT=16 unless noted)
REQ-032 req0 cmd=8'h05 data=16'h1234, resp=8'hA5 four cycles after snd_cmd -> snd_cmd in N+2 with 05/1234, done0=1 resp0=A5 err0=0.
REQ-033 req0 and req1 same cycle after reset -> requester 0 served first, then requester 1; third simultaneous pair -> 0 served (alternation).
REQ-034 req1 cmd=8'h02, no resp_rdy -> done1 and err1 pulse 17 cycles after snd_cmd, resp1=8'h00, FSM IDLE.
REQ-035 resp_rdy with resp=8'h3C exactly on timeout cycle -> done1=1, err1=0, resp1=3C.
REQ-036 Second req0 (cmd=8'hFF) while busy0 -> ignored; original command sent, only one done0.
REQ-037 rst_n low during WAIT -> all outputs 0 immediately; later resp_rdy produces no done.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the two-requester command arbiter.
//   arb_state_t : arbiter FSM state encoding
//   NUM_REQ     : number of requester slots
//   CNT_W       : width of the response-wait counter
package comm_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cmd_slot.sv
// Per-requester capture slot: holds one pending command until the arbiter
// takes it.
//   clk, rst_n : clock, async active-low reset
//   req        : one-cycle request pulse
//   cmd, data  : command byte / data word sampled with req
//   clear      : arbiter has granted this slot; drop the pending flag
//   active     : this slot's command currently owns the arbiter
//   pending    : a captured command is waiting for grant
//   busy       : pending or in flight; new requests are ignored while high
//   cmd_q      : latched command byte
//   data_q     : latched data word
module cmd_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        clear,
  input  logic        active,
  output logic        pending,
  output logic        busy,
  output logic [7:0]  cmd_q,
  output logic [15:0] data_q
);

  assign busy = pending | active;

  // clear only ever arrives while pending is set, so busy already blocks req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (req && !busy) begin
      pending <= 1'b1;
      cmd_q   <= cmd;
      data_q  <= data;
    end
  end

endmodule

// File: rtl/comm_arbiter.sv
// Two-requester arbiter in front of a command master. Each requester posts
// one command into its slot; the arbiter grants round-robin, issues a
// one-cycle frame request, and waits for a response byte or a timeout.
//   clk, rst_n          : clock, async active-low reset
//   req0/1, cmd0/1,
//   data0/1             : requester command pulses and payloads
//   busy0/1             : requester has a pending or in-flight command
//   done0/1, err0/1     : completion pulse / timeout flag (registered)
//   resp0/1             : response byte, held until that requester's next done
//   snd_cmd, cmd, data  : frame request to the command master
//   resp, resp_rdy      : response byte and its valid strobe
//
// state   | meaning
// IDLE    | no transaction; grant a pending slot if any
// SEND    | snd_cmd high for one cycle with owner's cmd/data
// WAIT    | counting cycles for resp_rdy or timeout
module comm_arbiter
  import comm_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [7:0]  cmd0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [7:0]  cmd1,
  input  logic [15:0] data1,
  output logic        busy0,
  output logic        busy1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  resp0,
  output logic [7:0]  resp1,
  output logic        snd_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic [7:0]  resp,
  input  logic        resp_rdy
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t                   state, state_nxt;
  logic                         owner, last_grant;
  logic [CNT_W-1:0]             cnt;
  logic [NUM_REQ-1:0]           pending, busy, clear, active;
  logic [NUM_REQ-1:0][7:0]      slot_cmd;
  logic [NUM_REQ-1:0][15:0]     slot_data;
  logic [NUM_REQ-1:0]           done_q, err_q;
  logic [NUM_REQ-1:0][7:0]      resp_q;
  logic                         grant, grant_id, finish, timeout;

  assign active[0] = (owner == 1'b0) && (state != ST_IDLE);
  assign active[1] = (owner == 1'b1) && (state != ST_IDLE);
  assign clear[0]  = grant && (grant_id == 1'b0);
  assign clear[1]  = grant && (grant_id == 1'b1);

  cmd_slot u_slot0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .cmd(cmd0), .data(data0),
    .clear(clear[0]), .active(active[0]), .pending(pending[0]),
    .busy(busy[0]), .cmd_q(slot_cmd[0]), .data_q(slot_data[0])
  );

  cmd_slot u_slot1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .cmd(cmd1), .data(data1),
    .clear(clear[1]), .active(active[1]), .pending(pending[1]),
    .busy(busy[1]), .cmd_q(slot_cmd[1]), .data_q(slot_data[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = owner;
    finish    = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          grant     = 1'b1;
          // on a tie the requester that was not granted last goes first
          grant_id  = (&pending) ? ~last_grant : pending[1];
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // a response arriving on the final count still counts as success
        if (resp_rdy) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == TO_LAST) begin
          finish    = 1'b1;
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      cmd        <= '0;
      data       <= '0;
      done_q     <= '0;
      err_q      <= '0;
      resp_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      if (grant) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        cmd        <= slot_cmd[grant_id];
        data       <= slot_data[grant_id];
      end
      if (state == ST_SEND)      cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + 1'b1;
      if (finish) begin
        done_q[owner] <= 1'b1;
        err_q[owner]  <= timeout;
        resp_q[owner] <= timeout ? 8'h00 : resp;
      end
    end
  end

  assign snd_cmd = (state == ST_SEND);
  assign busy0   = busy[0];
  assign busy1   = busy[1];
  assign done0   = done_q[0];
  assign done1   = done_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign resp0   = resp_q[0];
  assign resp1   = resp_q[1];

endmodule

// File: tb/tb_comm_arbiter.sv
module tb_comm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, resp_rdy;
  logic [7:0]  cmd0, cmd1, resp;
  logic [15:0] data0, data1;
  logic        busy0, busy1, done0, done1, err0, err1, snd_cmd;
  logic [7:0]  resp0, resp1, cmd;
  logic [15:0] data;

  int n_vec = 0;
  int n_err = 0;

  comm_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .data0(data0),
    .req1(req1), .cmd1(cmd1), .data1(data1),
    .busy0(busy0), .busy1(busy1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .resp0(resp0), .resp1(resp1),
    .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .resp(resp), .resp_rdy(resp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        req0;
    logic [7:0]  cmd0;
    logic [15:0] data0;
    logic        req1;
    logic [7:0]  cmd1;
    logic [15:0] data1;
    logic        rdy;
    logic [7:0]  resp;
    logic        snd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  resp0;
    logic [7:0]  resp1;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0 = 1'b0; req1 = 1'b0; resp_rdy = 1'b0;
    cmd0 = '0; cmd1 = '0; data0 = '0; data1 = '0; resp = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {17'd0, snd_cmd, cmd, data, busy1, busy0, done1, done0, err1, err0, resp0, resp1};
  endfunction

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // drive a request in the current cycle N; returns in cycle N+2
  task automatic issue(input int id, input logic [7:0] c, input logic [15:0] d);
    if (id == 0) begin req0 = 1'b1; cmd0 = c; data0 = d; end
    else         begin req1 = 1'b1; cmd1 = c; data1 = d; end
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int nd;
    vec_t v;
    logic [63:0] ev;

    idle_in();
    rst_n = 1'b0;

    // rst  r0 c0     d0        r1 c1     d1        rdy resp   | snd cmd    data       busy   done   err    resp0  resp1
    vecs.push_back('{1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h05, 16'h1234, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h05, 16'h1234, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h05, 16'h1234, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h05, 16'h1234, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'hA5, 1'b0, 8'h05, 16'h1234, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h05, 16'h1234, 2'b00, 2'b01, 2'b00, 8'hA5, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 8'h11, 16'h0011, 1'b1, 8'h22, 16'h2222, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h11, 16'h0011, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h5A, 1'b0, 8'h11, 16'h0011, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h11, 16'h0011, 2'b10, 2'b01, 2'b00, 8'h5A, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h22, 16'h2222, 2'b10, 2'b00, 2'b00, 8'h5A, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h6B, 1'b0, 8'h22, 16'h2222, 2'b10, 2'b00, 2'b00, 8'h5A, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h22, 16'h2222, 2'b00, 2'b10, 2'b00, 8'h5A, 8'h6B});
    // simultaneous pair again with a stray resp_rdy in IDLE
    vecs.push_back('{1'b1, 1'b1, 8'h33, 16'h3333, 1'b1, 8'h44, 16'h4444, 1'b1, 8'hEE, 1'b0, 8'h22, 16'h2222, 2'b00, 2'b00, 2'b00, 8'h5A, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h22, 16'h2222, 2'b11, 2'b00, 2'b00, 8'h5A, 8'h6B});
    // stray resp_rdy during SEND
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'hDD, 1'b1, 8'h33, 16'h3333, 2'b11, 2'b00, 2'b00, 8'h5A, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h77, 1'b0, 8'h33, 16'h3333, 2'b11, 2'b00, 2'b00, 8'h5A, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h33, 16'h3333, 2'b10, 2'b01, 2'b00, 8'h77, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h44, 16'h4444, 2'b10, 2'b00, 2'b00, 8'h77, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h88, 1'b0, 8'h44, 16'h4444, 2'b10, 2'b00, 2'b00, 8'h77, 8'h6B});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h44, 16'h4444, 2'b00, 2'b10, 2'b00, 8'h77, 8'h88});

    step();
    step();
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      step();
      rst_n = v.rst_n;
      req0 = v.req0; cmd0 = v.cmd0; data0 = v.data0;
      req1 = v.req1; cmd1 = v.cmd1; data1 = v.data1;
      resp_rdy = v.rdy; resp = v.resp;
      #1;
      ev = {17'd0, v.snd, v.cmd, v.data, v.busy, v.done, v.err, v.resp0, v.resp1};
      chk($sformatf("vec%0d", i), outs(), ev);
    end

    // timeout on requester 1, with resp1 primed non-zero first
    do_reset();
    issue(1, 8'h02, 16'h0BEE);
    step();
    resp_rdy = 1'b1; resp = 8'h99;
    step();
    resp_rdy = 1'b0;
    chk("prime_resp1", {55'd0, done1, resp1}, {55'd0, 1'b1, 8'h99});
    step();
    issue(1, 8'h02, 16'h0BEE);
    chk("to_snd", {47'd0, snd_cmd, cmd, data}, {47'd0, 1'b1, 8'h02, 16'h0BEE});
    n = 0;
    while (!done1 && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", 64'(n), 64'd17);
    chk("to_flags", {53'd0, done1, err1, done0, err0, resp1, snd_cmd, busy1},
        {53'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

    // response on the exact timeout cycle
    step();
    issue(1, 8'h03, 16'h0003);
    repeat (16) step();
    resp_rdy = 1'b1; resp = 8'h3C;
    step();
    resp_rdy = 1'b0;
    chk("race", {53'd0, done1, err1, resp1}, {53'd0, 1'b1, 1'b0, 8'h3C});

    // second request while busy is ignored
    step();
    req0 = 1'b1; cmd0 = 8'h44; data0 = 16'h4444;
    step();
    cmd0 = 8'hFF; data0 = 16'hFFFF;
    step();
    chk("busy_snd", {47'd0, snd_cmd, cmd, data}, {47'd0, 1'b1, 8'h44, 16'h4444});
    step();
    req0 = 1'b0;
    step();
    resp_rdy = 1'b1; resp = 8'h12;
    step();
    resp_rdy = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      nd += int'(done0);
      step();
    end
    chk("busy_one_done", 64'(nd), 64'd1);

    // reset during WAIT drops the transaction
    issue(0, 8'h55, 16'h5555);
    step();
    step();
    chk("rst_pre_busy", {63'd0, busy0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_midtx", outs(), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    resp_rdy = 1'b1; resp = 8'hEE;
    step();
    resp_rdy = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      nd += int'(done0) + int'(done1) + int'(snd_cmd);
      step();
    end
    chk("rst_no_done", 64'(nd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
